// File: rtl/arima_pkg.sv
// Shared types, default widths and the saturation classifier for the
// streaming AR anomaly detector.
package arima_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int FRAC_DEF   = 16;
  localparam int SAT_IW     = 160;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, MAC, CMP, DONE} state_e;

  typedef enum logic [1:0] {SAT_NONE, SAT_POS, SAT_NEG} sat_e;

  // Classifies a wide signed value against the range of a w-bit signed word.
  function automatic sat_e saturate(input logic signed [SAT_IW-1:0] v, input int w);
    logic signed [SAT_IW-1:0] one;
    logic signed [SAT_IW-1:0] hi;
    logic signed [SAT_IW-1:0] lo;
    one = 1;
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    if (v > hi) return SAT_POS;
    if (v < lo) return SAT_NEG;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/arima_mac.sv
// Sequential signed multiply-accumulate; the read port returns the next
// accumulator value rescaled by FRAC and saturated to DATA_W.
module arima_mac import arima_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int ACC_W  = 2 * DATA_W_DEF + 2
) (
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] rd_o,
  output logic                     ovf_o
);

  logic signed [2*DATA_W-1:0] prod_d;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    shifted_d;
  sat_e                       sat_d;

  always_comb begin
    prod_d = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
    acc_d  = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_W'(prod_d);
    shifted_d = acc_d >>> FRAC;
    sat_d     = saturate(SAT_IW'(shifted_d), DATA_W);
    ovf_o     = (sat_d != SAT_NONE);
    case (sat_d)
      SAT_POS: rd_o = {1'b0, {(DATA_W-1){1'b1}}};
      SAT_NEG: rd_o = {1'b1, {(DATA_W-1){1'b0}}};
      default: rd_o = shifted_d[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

endmodule

// File: rtl/arima_ad_stream.sv
// Streaming AR(P) predictor over an external sample BRAM; flags samples whose
// residual against the prediction exceeds THRESH.
module arima_ad_stream import arima_pkg::*; #(
  parameter  int                DATA_W    = DATA_W_DEF,
  parameter  int                FRAC      = FRAC_DEF,
  parameter  int                P         = 3,
  parameter  int                N_SAMPLES = 1024,
  parameter  logic [DATA_W-1:0] THRESH    = DATA_W'(32'h0002_0000),
  localparam int                ADDR_W    = $clog2(N_SAMPLES),
  localparam int                IDX_W     = (P > 1) ? $clog2(P) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     coeff_we,
  input  logic [IDX_W-1:0]         coeff_idx,
  input  logic signed [DATA_W-1:0] coeff_data,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic signed [DATA_W-1:0] mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] prediction,
  output logic                     label,
  output logic [ADDR_W-1:0]        time_step,
  output logic                     overflow,
  output logic [ADDR_W:0]          anomaly_count,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               leds
);

  localparam int ACC_W = 2 * DATA_W + $clog2(P);

  state_e                   state_q;
  logic [IDX_W-1:0]         mac_idx_q;
  logic signed [DATA_W-1:0] coeff_q [P];
  logic signed [DATA_W-1:0] hist_q  [P];
  logic signed [DATA_W-1:0] x_q;
  logic signed [DATA_W-1:0] pred_q;
  logic                     label_q;
  logic                     ovf_q;
  logic                     valid_q;
  logic                     rd_en_q;
  logic [ADDR_W-1:0]        ts_q;
  logic [ADDR_W:0]          cnt_q;
  logic                     busy_q;
  logic                     done_q;

  logic signed [DATA_W-1:0] mac_a_d;
  logic signed [DATA_W-1:0] mac_b_d;
  logic signed [DATA_W-1:0] mac_rd;
  logic                     mac_ovf;
  logic                     warm_d;
  logic signed [DATA_W:0]   diff_d;
  logic [DATA_W:0]          abs_d;
  logic                     hit_d;

  arima_mac #(.DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .clr_i (state_q == WAIT),
    .en_i  (state_q == MAC),
    .a_i   (mac_a_d),
    .b_i   (mac_b_d),
    .rd_o  (mac_rd),
    .ovf_o (mac_ovf)
  );

  // Residual is formed one bit wider than the samples so it can never wrap.
  always_comb begin
    mac_a_d = coeff_q[mac_idx_q];
    mac_b_d = hist_q[mac_idx_q];
    warm_d  = int'(ts_q) < P;
    diff_d  = {x_q[DATA_W-1], x_q} - {mac_rd[DATA_W-1], mac_rd};
    abs_d   = diff_d[DATA_W] ? -diff_d : diff_d;
    hit_d   = abs_d > {1'b0, THRESH};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      mac_idx_q <= '0;
      x_q       <= '0;
      pred_q    <= '0;
      label_q   <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      ts_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < P; i++) begin
        coeff_q[i] <= '0;
        hist_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (coeff_we && int'(coeff_idx) < P) coeff_q[coeff_idx] <= coeff_data;
          if (start) begin
            state_q <= FETCH;
            ts_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            pred_q  <= '0;
            label_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            rd_en_q <= 1'b1;
            for (int i = 0; i < P; i++) hist_q[i] <= '0;
          end
        end
        FETCH: begin
          rd_en_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          x_q       <= mem_rdata;
          mac_idx_q <= '0;
          state_q   <= MAC;
        end
        MAC: begin
          if (mac_idx_q == IDX_W'(P - 1)) begin
            valid_q <= 1'b1;
            state_q <= CMP;
            if (warm_d) begin
              pred_q  <= '0;
              label_q <= 1'b0;
            end else begin
              pred_q  <= mac_rd;
              label_q <= hit_d;
              if (mac_ovf) ovf_q <= 1'b1;
              if (hit_d)   cnt_q <= cnt_q + (ADDR_W+1)'(1);
            end
          end else begin
            mac_idx_q <= mac_idx_q + IDX_W'(1);
          end
        end
        CMP: begin
          if (out_ready) begin
            valid_q   <= 1'b0;
            hist_q[0] <= x_q;
            for (int i = P - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
            if (ts_q == ADDR_W'(N_SAMPLES - 1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              ts_q    <= ts_q + ADDR_W'(1);
              state_q <= FETCH;
              rd_en_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en     = rd_en_q;
  assign mem_addr      = ts_q;
  assign out_valid     = valid_q;
  assign prediction    = pred_q;
  assign label         = label_q;
  assign time_step     = ts_q;
  assign overflow      = ovf_q;
  assign anomaly_count = cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign leds          = {done_q, busy_q, ovf_q, label_q};

endmodule

// File: tb/tb_arima_ad_stream.sv
// Bench for arima_ad_stream: table of runs checked through a result scoreboard,
// plus stall, busy-write and mid-run reset sequences.
module tb_arima_ad_stream;

  localparam int PP = 3;
  localparam int NS = 64;
  localparam int AW = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              coeff_we = 1'b0;
  logic [1:0]        coeff_idx = '0;
  logic signed [31:0] coeff_data = '0;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic signed [31:0] mem_rdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [31:0] prediction;
  logic              label;
  logic [AW-1:0]     time_step;
  logic              overflow;
  logic [AW:0]       anomaly_count;
  logic              busy;
  logic              done;
  logic [3:0]        leds;

  arima_ad_stream #(
    .DATA_W(32), .FRAC(16), .P(PP), .N_SAMPLES(NS), .THRESH(32'h0002_0000)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .coeff_we(coeff_we),
    .coeff_idx(coeff_idx), .coeff_data(coeff_data), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .prediction(prediction), .label(label),
    .time_step(time_step), .overflow(overflow), .anomaly_count(anomaly_count),
    .busy(busy), .done(done), .leds(leds)
  );

  always #5 clk = ~clk;

  logic signed [31:0] mem [NS];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct packed {
    logic [31:0]   pred;
    logic          label;
    logic [AW-1:0] ts;
  } exp_t;

  typedef struct packed {
    logic [31:0] c0;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [2:0]  kind;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  exp_t               sbq[$];
  vec_t               tbl[6];
  logic signed [31:0] mcoef [PP];
  int                 checks = 0;
  int                 errors = 0;
  int                 reads = 0;
  int                 mcyc = 0;
  int                 prev_cyc = 0;
  logic               have_prev = 1'b0;
  logic               spacing_en = 1'b0;
  logic               m_ovf;
  logic               m_last_label;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_mem(input int kind);
    for (int t = 0; t < NS; t++) begin
      case (kind)
        1:       mem[t] = (t == 40) ? 32'sd10 * 65536 : t * 65536;
        2:       mem[t] = 30000 * 65536;
        3:       mem[t] = (t % 2 == 0) ? 3 * 65536 : -3 * 65536;
        default: mem[t] = t * 65536;
      endcase
    end
  endtask

  task automatic set_coef(input int idx, input logic [31:0] v, input logic to_model);
    @(negedge clk);
    coeff_we = 1'b1; coeff_idx = 2'(idx); coeff_data = v;
    @(negedge clk);
    coeff_we = 1'b0;
    if (to_model) mcoef[idx] = v;
  endtask

  task automatic build_expected();
    logic signed [95:0] acc, sh, a, b;
    logic signed [63:0] diff;
    logic [31:0]        p;
    logic               l;
    sbq.delete();
    m_ovf = 1'b0;
    m_last_label = 1'b0;
    for (int t = 0; t < NS; t++) begin
      acc = '0;
      for (int i = 0; i < PP; i++) begin
        a = mcoef[i];
        b = (t - 1 - i >= 0) ? mem[t-1-i] : 32'sd0;
        acc = acc + a * b;
      end
      sh = acc >>> 16;
      p = '0;
      l = 1'b0;
      if (t >= PP) begin
        if (sh > 96'sh7FFF_FFFF) begin p = 32'h7FFF_FFFF; m_ovf = 1'b1; end
        else if (sh < -96'sh8000_0000) begin p = 32'h8000_0000; m_ovf = 1'b1; end
        else p = sh[31:0];
        diff = 64'(mem[t]) - 64'($signed(p));
        if (diff < 0) diff = -diff;
        l = diff > 64'sh2_0000;
      end
      sbq.push_back('{pred: p, label: l, ts: AW'(t)});
      m_last_label = l;
    end
  endtask

  task automatic start_run(input logic spacing);
    build_expected();
    reads = 0;
    have_prev = 1'b0;
    spacing_en = spacing;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {busy, done}, 2'b10);
  endtask

  task automatic finish_run(input int exp_cnt, input logic exp_ovf, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("run_done_in_budget", done, 1);
    #2;
    chk("anomaly_count", anomaly_count, exp_cnt);
    chk("overflow", overflow, exp_ovf);
    chk("busy_in_done", busy, 0);
    chk("results_left", sbq.size(), 0);
    chk("bram_reads", reads, NS);
    chk("leds", leds, {1'b1, 1'b0, exp_ovf, m_last_label});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      mcyc++;
      if (mem_rd_en) reads++;
      if (out_valid) chk("rd_during_valid", mem_rd_en, 0);
      if (reset && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_result: t=%0d produced, none required", time_step);
        end else begin
          e = sbq.pop_front();
          chk("prediction", $unsigned(prediction), e.pred);
          chk("label", label, e.label);
          chk("time_step", time_step, e.ts);
          if (spacing_en && have_prev) chk("result_spacing", mcyc - prev_cyc, 6);
          prev_cyc = mcyc;
          have_prev = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic               found;
    logic               stable;
    logic [31:0]        rp;
    logic               rl;
    logic [AW-1:0]      rts;

    tbl[0] = '{32'h0001_0000, 32'h0, 32'h0, 3'd0, 8'd0, 1'b0};
    tbl[1] = '{32'h0001_0000, 32'h0, 32'h0, 3'd1, 8'd2, 1'b0};
    tbl[2] = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 3'd2, 8'd61, 1'b1};
    tbl[3] = '{32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 3'd2, 8'd61, 1'b1};
    tbl[4] = '{32'h0001_0000, 32'h0, 32'h0, 3'd3, 8'd61, 1'b0};
    tbl[5] = '{32'h0000_8000, 32'h0000_4000, 32'h0000_4000, 3'd0, 8'd0, 1'b0};
    for (int i = 0; i < PP; i++) mcoef[i] = '0;

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_valid, mem_rd_en, label, overflow, busy, done,
                          prediction, time_step, anomaly_count}, 0);
    chk("reset_leds", leds, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 6; v++) begin
      set_coef(0, tbl[v].c0, 1'b1);
      set_coef(1, tbl[v].c1, 1'b1);
      set_coef(2, tbl[v].c2, 1'b1);
      fill_mem(int'(tbl[v].kind));
      start_run(1'b1);
      finish_run(int'(tbl[v].exp_cnt), tbl[v].exp_ovf, NS * 6 + 50);
      repeat (5) @(negedge clk);
      chk("flags_held_in_done", {done, overflow}, {1'b1, tbl[v].exp_ovf});
    end

    // Coefficient writes and start while busy are ignored; a write in DONE sticks.
    set_coef(0, 32'h0001_0000, 1'b1);
    set_coef(1, 32'h0, 1'b1);
    set_coef(2, 32'h0, 1'b1);
    fill_mem(0);
    start_run(1'b1);
    repeat (30) @(negedge clk);
    set_coef(0, 32'h0000_8000, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    finish_run(0, 1'b0, NS * 6 + 50);
    set_coef(0, 32'h0000_8000, 1'b1);
    set_coef(1, 32'h0000_8000, 1'b1);
    start_run(1'b1);
    finish_run(0, 1'b0, NS * 6 + 50);

    // Consumer stalls the result at t=5 for ten cycles.
    start_run(1'b0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (time_step == AW'(5) && !out_valid) begin found = 1'b1; break; end
    end
    chk("stall_reach_t5", found, 1);
    out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) begin found = 1'b1; break; end
    end
    chk("stall_valid_seen", found, 1);
    rp = prediction; rl = label; rts = time_step;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || prediction !== $signed(rp) || label !== rl ||
          time_step !== rts || mem_rd_en) stable = 1'b0;
    end
    chk("stall_fields_stable", stable, 1);
    chk("stall_time_step", rts, 5);
    out_ready = 1'b1;
    finish_run(0, 1'b0, NS * 6 + 100);

    // Reset mid-MAC, with start and a coefficient write competing in that cycle.
    set_coef(0, 32'h0001_0000, 1'b1);
    set_coef(1, 32'h0, 1'b1);
    start_run(1'b1);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (time_step == AW'(20) && mem_rd_en) begin found = 1'b1; break; end
    end
    chk("reach_t20_fetch", found, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0; start = 1'b1;
    coeff_we = 1'b1; coeff_idx = 2'd0; coeff_data = 32'h0001_0000;
    @(negedge clk);
    chk("midrun_reset_outputs", {out_valid, mem_rd_en, label, overflow, busy, done,
                                 prediction, time_step, anomaly_count}, 0);
    reset = 1'b1; start = 1'b0; coeff_we = 1'b0;
    sbq.delete();
    for (int i = 0; i < PP; i++) mcoef[i] = '0;
    @(negedge clk);
    chk("idle_after_reset", {busy, done}, 0);
    start_run(1'b1);
    finish_run(61, 1'b0, NS * 6 + 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arima_ad_stream.md
ARIMA_AD_STREAM -- requirements
Module: arima_ad_stream

Interface
REQ-001 Parameter DATA_W, default 32, signed sample/coefficient width, fixed point Q(DATA_W-FRAC).FRAC.
REQ-002 Parameter FRAC, default 16, fractional bits.
REQ-003 Parameter P, default 3, AR order (1..8).
REQ-004 Parameter N_SAMPLES, default 1024, samples per run; ADDR_W = clog2(N_SAMPLES).
REQ-005 Parameter THRESH, default 32'h0002_0000, absolute-residual anomaly threshold.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 start  in  1  level; sampled in IDLE/DONE to begin a run.
REQ-009 coeff_we, coeff_idx, coeff_data  in  1, clog2(P), DATA_W  coefficient write port.
REQ-010 mem_rd_en, mem_addr  out  1, ADDR_W  sample BRAM read request.
REQ-011 mem_rdata  in  DATA_W  BRAM data, valid exactly 1 cycle after mem_rd_en.
REQ-012 out_valid  out  1; out_ready  in  1  result handshake.
REQ-013 prediction  out  DATA_W; label  out  1; time_step  out  ADDR_W  result fields, stable while out_valid.
REQ-014 overflow  out  1  sticky saturation flag for current run.
REQ-015 anomaly_count  out  ADDR_W+1  anomalies this run.
REQ-016 busy, done  out  1 each.
REQ-017 leds  out  4  = {done, busy, overflow, label}.

Function
REQ-018 FSM states IDLE, FETCH, WAIT, MAC, CMP, DONE.
REQ-019 IDLE: start=1 -> FETCH, clear time_step, anomaly_count, overflow, history; busy=1 from next cycle.
REQ-020 FETCH: mem_rd_en=1, mem_addr=time_step for exactly one cycle -> WAIT.
REQ-021 WAIT: capture mem_rdata as x_t -> MAC; accumulator cleared.
REQ-022 MAC: P cycles, cycle i adds coeff[i]*hist[i] (hist[0]=x_{t-1}) into 2*DATA_W+clog2(P) signed accumulator -> CMP.
REQ-023 prediction = accumulator arithmetic-shifted right by FRAC, saturated to DATA_W; saturation sets overflow.
REQ-024 residual = |x_t - prediction| computed at DATA_W+1 bits, no wrap.
REQ-025 Warm-up: for time_step < P prediction=0, label=0, count unchanged.
REQ-026 Otherwise label = residual > THRESH (strict); label=1 increments anomaly_count.
REQ-027 CMP: out_valid=1; held with fields stable until out_ready=1; on handshake shift x_t into hist, increment time_step.
REQ-028 Throughput with out_ready tied high: one result every P+3 cycles.
REQ-029 After handshake at time_step=N_SAMPLES-1 -> DONE; else -> FETCH.
REQ-030 DONE: done=1, busy=0, counters/overflow held; start=1 -> new run as REQ-019.
REQ-031 start while busy ignored.
REQ-032 coeff_we accepted only in IDLE/DONE; ignored when busy; coefficients persist across runs.
REQ-033 out_ready before out_valid has no effect; no result is ever dropped or duplicated.

Reset
REQ-034 reset=0 at any edge, including mid-run: state IDLE; outputs out_valid, mem_rd_en, label, overflow, busy, done, prediction, time_step, anomaly_count = 0; history cleared.
REQ-035 Coefficients reset to 0.
REQ-036 reset dominates start and coeff_we in the same cycle.

Structure
REQ-037 Package arima_pkg holds the FSM state enum, DATA_W/FRAC defaults and the saturate function.
REQ-038 One sub-module arima_mac: sequential multiply-accumulate with clear, enable, saturate-on-read; no other hierarchy.
REQ-039 BRAM is external; block contains no sample storage beyond P-entry history.

Verification
REQ-040 P=3, coeffs {1.0,0,0}, ramp samples 0,1.0,2.0,... , out_ready=1 -> prediction(t)=x_{t-1} for t>=3, label=0, result spacing 6 cycles.
REQ-041 Same, sample 40 = 10.0 in ramp -> label=1 at t=40 and t=41, anomaly_count=2 at done.
REQ-042 coeffs {32767.0,32767.0,32767.0}, samples 30000.0 -> prediction=32'h7FFF_FFFF, overflow=1 sticky through DONE.
REQ-043 out_ready held 0 for 10 cycles at t=5 -> out_valid and fields stable 10 cycles, no mem_rd_en issued, t=5 reported once.
REQ-044 reset=0 at t=100 mid-MAC -> next cycle all REQ-034 outputs 0, start then restarts at time_step=0.
REQ-045 coeff_we during busy with new value -> ignored; run results match unmodified coefficients; write in DONE takes effect next run.
